y_edge_logger: RTL and testbench



---
 rtl/y_log_pkg.sv | 16 +
 rtl/y_edge_logger_evt_fifo.sv | 46 ++++
 rtl/y_edge_logger.sv | 146 ++++++++++++++
 tb/tb_y_edge_logger.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/y_log_pkg.sv
// Shared types and default constants for the Y edge logger.
// evt_t describes one logged edge at the default timestamp width.
package y_log_pkg;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;
    localparam int DEF_TS_W          = 16;
    localparam int DEF_DEPTH         = 4;

    typedef enum logic {ST_STABLE, ST_QUALIFY} filt_state_e;

    typedef struct packed {
        logic                dir;
        logic [DEF_TS_W-1:0] ts;
    } evt_t;
endpackage

// File: rtl/y_edge_logger_evt_fifo.sv
// Small synchronous FIFO for edge events; flush empties it and wins over push/pop.
// A push while full only succeeds when a pop frees a slot in the same cycle.
module evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;
    logic         do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero when empty so outputs read 0 out of reset and clear.
    assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= din;
                wr_q                <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
        end
    end
endmodule

// File: rtl/y_edge_logger.sv
// Synchronises and glitch-filters the async Y signal, counts accepted rises and
// logs timestamped edges into a FIFO drained over valid/ready.
module y_edge_logger
    import y_log_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int TS_W          = DEF_TS_W,
    parameter int DEPTH         = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             y_in,
    input  logic             clear,
    output logic             y_filt,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] rise_cnt,
    output logic             cnt_sat,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_dir,
    output logic [TS_W-1:0]  evt_ts,
    output logic             overflow
);
    localparam int QW = $clog2(STABLE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   y_s;
    filt_state_e            state_q, state_d;
    logic [QW-1:0]          qcnt_q, qcnt_d;
    logic                   upd;
    logic                   y_filt_q, y_filt_d;
    logic                   rise_q, rise_d, fall_q, fall_d;
    logic [TS_W-1:0]        ts_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovf_q;
    logic                   f_push, f_pop, f_full, f_empty;
    logic [TS_W:0]          f_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], y_in};
    end
    assign y_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            qcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
        end
    end

    // qcnt holds how many consecutive mismatching samples have been seen.
    always_comb begin
        state_d = state_q;
        qcnt_d  = '0;
        upd     = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (y_s != y_filt_q) begin
                    if (STABLE_CYCLES == 1) begin
                        upd = 1'b1;
                    end else begin
                        state_d = ST_QUALIFY;
                        qcnt_d  = QW'(1);
                    end
                end
            end
            ST_QUALIFY: begin
                if (y_s == y_filt_q) begin
                    state_d = ST_STABLE;
                end else if (qcnt_q == QW'(STABLE_CYCLES - 1)) begin
                    upd     = 1'b1;
                    state_d = ST_STABLE;
                end else begin
                    qcnt_d  = qcnt_q + QW'(1);
                end
            end
            default: state_d = ST_STABLE;
        endcase
    end

    always_comb begin
        y_filt_d = upd ? y_s : y_filt_q;
        rise_d   = upd && y_s;
        fall_d   = upd && !y_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_filt_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            ts_q     <= '0;
        end else begin
            y_filt_q <= y_filt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            ts_q     <= ts_q + TS_W'(1);
        end
    end

    // clear discards any coinciding event or pop; the filter path keeps running.
    assign f_push = upd && !clear;
    assign f_pop  = evt_valid && evt_ready && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (rise_d && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
            if (f_push && f_full && !f_pop) ovf_q <= 1'b1;
        end
    end

    evt_fifo #(.DEPTH(DEPTH), .W(TS_W + 1)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (f_push),
        .pop   (f_pop),
        .flush (clear),
        .din   ({y_s, ts_q}),
        .full  (f_full),
        .empty (f_empty),
        .dout  (f_dout)
    );

    assign y_filt     = y_filt_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign rise_cnt   = cnt_q;
    assign cnt_sat    = &cnt_q;
    assign evt_valid  = !f_empty;
    assign evt_dir    = f_dout[TS_W];
    assign evt_ts     = f_dout[TS_W-1:0];
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_y_edge_logger.sv
// Scenario bench for y_edge_logger: scoreboard of expected events, narrow counter
// so saturation is reachable quickly.
module tb_y_edge_logger;
    import y_log_pkg::*;

    localparam int CW = 2;
    localparam int D  = 4;
    localparam int OW = 1 + 1 + 1 + CW + 1 + 1 + 1 + DEF_TS_W + 1;

    logic                clk = 1'b0, rst_n = 1'b1, y_in = 1'b0, clear = 1'b0, evt_ready = 1'b0;
    logic                y_filt, rise_pulse, fall_pulse, cnt_sat, evt_valid, evt_dir, overflow;
    logic [CW-1:0]       rise_cnt;
    logic [DEF_TS_W-1:0] evt_ts;
    logic [OW-1:0]       all_out;

    y_edge_logger #(
        .SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(CW), .TS_W(DEF_TS_W), .DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .y_in(y_in), .clear(clear),
        .y_filt(y_filt), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .rise_cnt(rise_cnt), .cnt_sat(cnt_sat), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_dir(evt_dir), .evt_ts(evt_ts), .overflow(overflow)
    );

    always #5 clk = ~clk;

    assign all_out = {y_filt, rise_pulse, fall_pulse, rise_cnt, cnt_sat, evt_valid,
                      evt_dir, evt_ts, overflow};

    int   total = 0, bad = 0;
    int   cyc;
    evt_t sb[$];
    int   exp_cnt;
    logic exp_ovf;

    // Edge index since reset release: the value ts should hold after that edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (all_out !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        exp_ovf = 1'b0;
        sb.delete();
    endtask

    // Drive a settled level change and check the qualified edge at edge n+6.
    task automatic edge_to(input logic v);
        int   n;
        evt_t e;
        @(negedge clk);
        y_in = v;
        n = cyc;
        repeat (5) @(negedge clk);
        total++;
        if (y_filt !== !v) begin bad++; $display("FAIL early_filt got=%b exp=%b", y_filt, !v); end
        @(negedge clk);
        if (v && exp_cnt != 3) exp_cnt++;
        e.dir = v;
        e.ts  = DEF_TS_W'(n + 5);
        if (sb.size() < D) sb.push_back(e);
        else exp_ovf = 1'b1;
        total++;
        if (y_filt !== v) begin bad++; $display("FAIL filt got=%b exp=%b", y_filt, v); end
        total++;
        if ({rise_pulse, fall_pulse} !== {v, !v})
            begin bad++; $display("FAIL pulses got=%b%b exp=%b%b", rise_pulse, fall_pulse, v, !v); end
        total++;
        if (rise_cnt !== CW'(exp_cnt) || cnt_sat !== (exp_cnt == 3))
            begin bad++; $display("FAIL rise_cnt got=%0d/%b exp=%0d", rise_cnt, cnt_sat, exp_cnt); end
        total++;
        if (overflow !== exp_ovf) begin bad++; $display("FAIL overflow got=%b exp=%b", overflow, exp_ovf); end
        total++;
        if (evt_valid !== 1'b1 || {evt_dir, evt_ts} !== {sb[0].dir, sb[0].ts})
            begin bad++; $display("FAIL head got=%b %b/%0d exp=1 %b/%0d", evt_valid, evt_dir, evt_ts, sb[0].dir, sb[0].ts); end
        @(negedge clk);
        total++;
        if ({rise_pulse, fall_pulse} !== 2'b00)
            begin bad++; $display("FAIL pulse_width got=%b%b exp=00", rise_pulse, fall_pulse); end
    endtask

    task automatic drain(input int n_exp);
        int   got = 0;
        evt_t e;
        evt_ready = 1'b1;
        for (int g = 0; g < D + 4; g++) begin
            if (!evt_valid) break;
            total++;
            if (sb.size() == 0) begin
                bad++; $display("FAIL drain_extra got=%b/%0d exp=none", evt_dir, evt_ts);
            end else begin
                e = sb.pop_front();
                if ({evt_dir, evt_ts} !== {e.dir, e.ts})
                    begin bad++; $display("FAIL drain_entry got=%b/%0d exp=%b/%0d", evt_dir, evt_ts, e.dir, e.ts); end
            end
            got++;
            @(negedge clk);
        end
        evt_ready = 1'b0;
        total++;
        if (got != n_exp || sb.size() != 0)
            begin bad++; $display("FAIL drain_count got=%0d exp=%0d left=%0d", got, n_exp, sb.size()); end
    endtask

    task automatic test_clean_rise();
        edge_to(1'b1);
        drain(1);
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL pop_empty got=%b exp=0", evt_valid); end
        edge_to(1'b0);
        drain(1);
    endtask

    task automatic test_glitch();
        @(negedge clk);
        y_in = 1'b1;
        repeat (3) @(negedge clk);
        y_in = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            total++;
            if ({y_filt, rise_pulse, fall_pulse} !== 3'b000)
                begin bad++; $display("FAIL glitch got=%b%b%b exp=000", y_filt, rise_pulse, fall_pulse); end
        end
        total++;
        if (rise_cnt !== CW'(exp_cnt) || evt_valid !== 1'b0)
            begin bad++; $display("FAIL glitch_state got=%0d/%b exp=%0d/0", rise_cnt, evt_valid, exp_cnt); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            edge_to((i % 2) == 0);
            repeat (3) @(negedge clk);
        end
        total++;
        if (overflow !== 1'b1 || sb.size() != D)
            begin bad++; $display("FAIL ovf_set got=%b exp=1 q=%0d", overflow, sb.size()); end
        drain(D);
    endtask

    task automatic test_sat();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        sb.delete(); exp_cnt = 0; exp_ovf = 1'b0;
        total++;
        if ({rise_cnt, overflow, evt_valid} !== '0)
            begin bad++; $display("FAIL clear got=%0d/%b/%b exp=0/0/0", rise_cnt, overflow, evt_valid); end
        for (int i = 0; i < 5; i++) begin
            edge_to(1'b0);
            edge_to(1'b1);
        end
    endtask

    task automatic test_clear_edge();
        edge_to(1'b0);
        @(negedge clk);
        y_in = 1'b1;
        repeat (5) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        sb.delete(); exp_cnt = 0; exp_ovf = 1'b0;
        total++;
        if ({y_filt, rise_pulse} !== 2'b11)
            begin bad++; $display("FAIL clr_filt got=%b%b exp=11", y_filt, rise_pulse); end
        total++;
        if ({rise_cnt, evt_valid, overflow} !== '0)
            begin bad++; $display("FAIL clr_state got=%0d/%b/%b exp=0/0/0", rise_cnt, evt_valid, overflow); end
        repeat (3) @(negedge clk);
        total++;
        if ({rise_cnt, evt_valid, overflow} !== '0)
            begin bad++; $display("FAIL clr_after got=%0d/%b/%b exp=0/0/0", rise_cnt, evt_valid, overflow); end
    endtask

    task automatic test_reset_mid();
        edge_to(1'b0);
        edge_to(1'b1);
        @(negedge clk);
        y_in = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (evt_valid !== 1'b1 || y_filt !== 1'b1)
            begin bad++; $display("FAIL pre_reset got=%b%b exp=11", evt_valid, y_filt); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (all_out !== '0) begin bad++; $display("FAIL mid_reset got=%h exp=0", all_out); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete(); exp_cnt = 0; exp_ovf = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (all_out !== '0) begin bad++; $display("FAIL post_reset got=%h exp=0 cyc=%0d", all_out, i); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_overflow();
        test_sat();
        test_clear_edge();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
